// File: rtl/tcdm_arb_pkg.sv
// Shared defaults and ID typing for the TCDM round-robin arbiter.
// Pure declarations: no logic, no latency.
// No flow control here; consumers size their ports from these values.
package tcdm_arb_pkg;

    localparam int NB_REQ_DEFAULT          = 3;
    localparam int MAX_OUTSTANDING_DEFAULT = 2;

    // A single requester still needs a 1-bit ID so the FIFO has something to store.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int REQ_ID_W = (NB_REQ_DEFAULT > 1) ? $clog2(NB_REQ_DEFAULT) : 1;

    typedef logic [REQ_ID_W-1:0] req_id_t;

endpackage

// File: rtl/tcdm_arb_id_fifo.sv
// In-order FIFO of granted requester IDs, used to route responses back.
// Latency: rdata shows the head combinationally; push visible at head next cycle.
// Backpressure: push ignored when full, pop ignored when empty; push+pop keeps occupancy.
module tcdm_arb_id_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/tcdm_rr_arbiter.sv
// Round-robin arbiter of NB_REQ TCDM masters onto one memory port, responses routed in order.
// Latency: grant and response routing are combinational (zero added cycles).
// Backpressure: mem_gnt_i stalls with the selection locked; mem_req_o drops at MAX_OUTSTANDING.
module tcdm_rr_arbiter
    import tcdm_arb_pkg::*;
#(
    parameter int NB_REQ          = NB_REQ_DEFAULT,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NB_REQ-1:0]                       req_i,
    input  logic [NB_REQ-1:0][ADDR_WIDTH-1:0]       addr_i,
    input  logic [NB_REQ-1:0]                       we_i,
    input  logic [NB_REQ-1:0][DATA_WIDTH/8-1:0]     be_i,
    input  logic [NB_REQ-1:0][DATA_WIDTH-1:0]       wdata_i,
    output logic [NB_REQ-1:0]                       gnt_o,
    output logic [NB_REQ-1:0]                       rvalid_o,
    output logic [DATA_WIDTH-1:0]                   rdata_o,
    output logic                                    mem_req_o,
    output logic [ADDR_WIDTH-1:0]                   mem_addr_o,
    output logic                                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0]                 mem_be_o,
    output logic [DATA_WIDTH-1:0]                   mem_wdata_o,
    input  logic                                    mem_gnt_i,
    input  logic                                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                   mem_rdata_i,
    output logic                                    err_o
);

    localparam int              IDW      = id_width(NB_REQ);
    localparam logic [IDW-1:0]  LAST_RST = IDW'(NB_REQ - 1);

    logic [IDW-1:0] last_q;
    logic [IDW-1:0] lock_sel_q;
    logic           lock_q;
    logic           err_q;
    logic [IDW-1:0] rr_sel;
    logic [IDW-1:0] sel;
    logic [IDW-1:0] head_id;
    logic           lock_hold;
    logic           handshake;
    logic           fifo_full;
    logic           fifo_empty;
    logic           resp_ok;

    // Scan offsets from farthest to nearest so the nearest requester after last_q wins.
    always_comb begin
        int sum;
        rr_sel = '0;
        for (int k = NB_REQ; k >= 1; k--) begin
            sum = int'(last_q) + k;
            if (sum >= NB_REQ) sum = sum - NB_REQ;
            if (req_i[sum[IDW-1:0]]) rr_sel = sum[IDW-1:0];
        end
    end

    assign lock_hold = lock_q & req_i[lock_sel_q];
    assign sel       = lock_hold ? lock_sel_q : rr_sel;

    assign mem_req_o   = (|req_i) & ~fifo_full;
    assign handshake   = mem_req_o & mem_gnt_i;
    assign mem_addr_o  = addr_i[sel];
    assign mem_we_o    = we_i[sel];
    assign mem_be_o    = be_i[sel];
    assign mem_wdata_o = wdata_i[sel];

    assign resp_ok = mem_rvalid_i & ~fifo_empty;
    assign rdata_o = mem_rdata_i;
    assign err_o   = err_q;

    always_comb begin
        gnt_o           = '0;
        gnt_o[sel]      = handshake;
        rvalid_o        = '0;
        rvalid_o[head_id] = resp_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q     <= LAST_RST;
            lock_q     <= 1'b0;
            lock_sel_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (handshake) begin
                last_q <= sel;
                lock_q <= 1'b0;
            end else if (mem_req_o) begin
                lock_q     <= 1'b1;
                lock_sel_q <= sel;
            end else begin
                lock_q <= 1'b0;
            end
            if (mem_rvalid_i & fifo_empty) err_q <= 1'b1;
        end
    end

    tcdm_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IDW)
    ) u_id_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (handshake),
        .pop   (mem_rvalid_i),
        .wdata (sel),
        .rdata (head_id),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_tcdm_rr_arbiter.sv
// Bench for tcdm_rr_arbiter: directed vector table, corner-case sequences, randomized model comparison.
module tb_tcdm_rr_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N-1:0]            req_i;
    logic [N-1:0][AW-1:0]    addr_i;
    logic [N-1:0]            we_i;
    logic [N-1:0][DW/8-1:0]  be_i;
    logic [N-1:0][DW-1:0]    wdata_i;
    logic [N-1:0]            gnt_o;
    logic [N-1:0]            rvalid_o;
    logic [DW-1:0]           rdata_o;
    logic                    mem_req_o;
    logic [AW-1:0]           mem_addr_o;
    logic                    mem_we_o;
    logic [DW/8-1:0]         mem_be_o;
    logic [DW-1:0]           mem_wdata_o;
    logic                    mem_gnt_i;
    logic                    mem_rvalid_i;
    logic [DW-1:0]           mem_rdata_i;
    logic                    err_o;

    always #5 clk = ~clk;

    tcdm_rr_arbiter #(
        .NB_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .addr_i(addr_i), .we_i(we_i),
        .be_i(be_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .err_o(err_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chk_cmd(input string name, input int s);
        chk({name, ".addr"},  mem_addr_o,  addr_i[s]);
        chk({name, ".we"},    mem_we_o,    we_i[s]);
        chk({name, ".be"},    mem_be_o,    be_i[s]);
        chk({name, ".wdata"}, mem_wdata_o, wdata_i[s]);
    endtask

    task automatic set_default_cmds();
        for (int k = 0; k < N; k++) begin
            addr_i[k]  = 32'h1000_0000 + 32'(k * 16);
            we_i[k]    = k[0];
            be_i[k]    = 4'(1 << k);
            wdata_i[k] = 32'hD000_0000 + 32'(k);
        end
    endtask

    task automatic drive(input logic r, input logic [N-1:0] q, input logic g, input logic v);
        rst          = r;
        req_i        = q;
        mem_gnt_i    = g;
        mem_rvalid_i = v;
        mem_rdata_i  = $urandom;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference model state: arbitration pointer, held selection, pending-ID queue, error flag.
    int m_last;
    bit m_lock_v;
    int m_lock_idx;
    int m_q[$];
    bit m_err;

    task automatic model_reset();
        m_last   = N - 1;
        m_lock_v = 0;
        m_lock_idx = 0;
        m_q.delete();
        m_err    = 0;
    endtask

    task automatic do_reset();
        drive(1'b1, '0, 1'b0, 1'b0);
        next_cycle();
        next_cycle();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic model_eval(output bit mreq, output logic [N-1:0] g,
                              output logic [N-1:0] rv, output int sel);
        sel = -1;
        if (m_lock_v && req_i[m_lock_idx]) sel = m_lock_idx;
        else begin
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (m_last + k) % N;
                if (sel < 0 && req_i[i]) sel = i;
            end
        end
        mreq = (req_i != 0) && (m_q.size() < MO);
        g    = (mreq && mem_gnt_i) ? N'(1 << sel) : '0;
        rv   = (mem_rvalid_i && m_q.size() > 0) ? N'(1 << m_q[0]) : '0;
    endtask

    task automatic model_step(input bit mreq, input int sel);
        if (rst) model_reset();
        else begin
            if (mem_rvalid_i) begin
                if (m_q.size() > 0) void'(m_q.pop_front());
                else m_err = 1;
            end
            if (mreq && mem_gnt_i) begin
                m_q.push_back(sel);
                m_last   = sel;
                m_lock_v = 0;
            end else if (mreq) begin
                m_lock_v   = 1;
                m_lock_idx = sel;
            end else m_lock_v = 0;
        end
    endtask

    typedef struct {
        logic         rst;
        logic [N-1:0] req;
        logic         gnt;
        logic         rv;
        logic         mreq;
        logic [N-1:0] gnt_e;
        logic [N-1:0] rv_e;
        logic         err;
        int           sel;
    } vec_t;

    vec_t vecs[24];

    initial begin
        bit           e_mreq;
        logic [N-1:0] e_gnt;
        logic [N-1:0] e_rv;
        int           e_sel;

        // rst req gnt rv | mreq gnt_e rv_e err sel
        vecs[0]  = '{1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, -1};
        vecs[1]  = '{1'b0, 3'b100, 1'b1, 1'b0, 1'b1, 3'b100, 3'b000, 1'b0,  2};
        vecs[2]  = '{1'b0, 3'b001, 1'b1, 1'b0, 1'b1, 3'b001, 3'b000, 1'b0,  0};
        vecs[3]  = '{1'b0, 3'b011, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, -1};
        vecs[4]  = '{1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 3'b100, 1'b0, -1};
        vecs[5]  = '{1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 3'b001, 1'b0, -1};
        vecs[6]  = '{1'b0, 3'b010, 1'b1, 1'b0, 1'b1, 3'b010, 3'b000, 1'b0,  1};
        vecs[7]  = '{1'b0, 3'b100, 1'b1, 1'b1, 1'b1, 3'b100, 3'b010, 1'b0,  2};
        vecs[8]  = '{1'b0, 3'b111, 1'b1, 1'b0, 1'b1, 3'b001, 3'b000, 1'b0,  0};
        vecs[9]  = '{1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, -1};
        vecs[10] = '{1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 3'b100, 1'b0, -1};
        vecs[11] = '{1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 3'b001, 1'b0, -1};
        vecs[12] = '{1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0, -1};
        vecs[13] = '{1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1, -1};
        vecs[14] = '{1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1, -1};
        vecs[15] = '{1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, -1};
        vecs[16] = '{1'b0, 3'b010, 1'b1, 1'b0, 1'b1, 3'b010, 3'b000, 1'b0,  1};
        vecs[17] = '{1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, -1};
        vecs[18] = '{1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0, -1};
        vecs[19] = '{1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1, -1};
        vecs[20] = '{1'b0, 3'b111, 1'b1, 1'b0, 1'b1, 3'b001, 3'b000, 1'b1,  0};
        vecs[21] = '{1'b0, 3'b111, 1'b1, 1'b0, 1'b1, 3'b010, 3'b000, 1'b1,  1};
        vecs[22] = '{1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 3'b001, 1'b1, -1};
        vecs[23] = '{1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 3'b010, 1'b1, -1};

        set_default_cmds();
        do_reset();

        for (int i = 0; i < 24; i++) begin
            drive(vecs[i].rst, vecs[i].req, vecs[i].gnt, vecs[i].rv);
            @(negedge clk);
            chk($sformatf("vec%0d.mem_req", i), mem_req_o, vecs[i].mreq);
            chk($sformatf("vec%0d.gnt", i),     gnt_o,     vecs[i].gnt_e);
            chk($sformatf("vec%0d.rvalid", i),  rvalid_o,  vecs[i].rv_e);
            chk($sformatf("vec%0d.err", i),     err_o,     vecs[i].err);
            chk($sformatf("vec%0d.rdata", i),   rdata_o,   mem_rdata_i);
            if (vecs[i].sel >= 0) chk_cmd($sformatf("vec%0d", i), vecs[i].sel);
            next_cycle();
        end

        // Saturated round-robin with the memory answering one cycle after every grant.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, (c < 9) ? 3'b111 : 3'b000, 1'b1, c > 0);
            @(negedge clk);
            chk($sformatf("rr%0d.gnt", c), gnt_o, (c < 9) ? 3'(1 << (c % 3)) : 3'b000);
            chk($sformatf("rr%0d.rvalid", c), rvalid_o, (c > 0) ? 3'(1 << ((c - 1) % 3)) : 3'b000);
            next_cycle();
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        chk("rr.err", err_o, 1'b0);
        next_cycle();

        // Stalled request keeps its command stable while a competitor arrives.
        do_reset();
        addr_i[1] = 32'h0010_0040;
        for (int c = 1; c <= 4; c++) begin
            drive(1'b0, (c >= 2) ? 3'b110 : 3'b010, c == 4, 1'b0);
            @(negedge clk);
            chk($sformatf("stall%0d.addr", c), mem_addr_o, 32'h0010_0040);
            chk($sformatf("stall%0d.gnt", c), gnt_o, (c == 4) ? 3'b010 : 3'b000);
            next_cycle();
        end
        drive(1'b0, 3'b000, 1'b0, 1'b1);
        @(negedge clk);
        chk("stall.rvalid", rvalid_o, 3'b010);
        next_cycle();
        set_default_cmds();

        // Lock outranks the round-robin pointer: requester 2 held although 1 is next in turn.
        drive(1'b0, 3'b001, 1'b1, 1'b0);
        @(negedge clk);
        chk("lock.g0", gnt_o, 3'b001);
        next_cycle();
        drive(1'b0, 3'b100, 1'b0, 1'b0);
        next_cycle();
        drive(1'b0, 3'b110, 1'b0, 1'b0);
        @(negedge clk);
        chk_cmd("lock.held", 2);
        next_cycle();
        drive(1'b0, 3'b110, 1'b1, 1'b0);
        @(negedge clk);
        chk("lock.g2", gnt_o, 3'b100);
        next_cycle();
        drive(1'b0, 3'b000, 1'b0, 1'b1);
        @(negedge clk);
        chk("lock.rv0", rvalid_o, 3'b001);
        next_cycle();
        drive(1'b0, 3'b000, 1'b0, 1'b1);
        @(negedge clk);
        chk("lock.rv2", rvalid_o, 3'b100);
        next_cycle();

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) begin
                addr_i[k]  = $urandom;
                we_i[k]    = 1'($urandom_range(0, 1));
                be_i[k]    = 4'($urandom_range(0, 15));
                wdata_i[k] = $urandom;
            end
            drive($urandom_range(0, 99) == 0, N'($urandom_range(0, 7)),
                  $urandom_range(0, 3) != 0,
                  (m_q.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0));
            @(negedge clk);
            model_eval(e_mreq, e_gnt, e_rv, e_sel);
            chk("rnd.mem_req", mem_req_o, e_mreq);
            chk("rnd.gnt",     gnt_o,     e_gnt);
            chk("rnd.rvalid",  rvalid_o,  e_rv);
            chk("rnd.err",     err_o,     m_err);
            chk("rnd.rdata",   rdata_o,   mem_rdata_i);
            if (e_mreq) chk_cmd("rnd", e_sel);
            model_step(e_mreq, e_sel);
            next_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tcdm_rr_arbiter.md
TCDM_RR_ARBITER -- requirements
Module: tcdm_rr_arbiter

Interface
REQ-001 SHALL have parameter NB_REQ, default 3, number of requesters (0 core data, 1 debug, 2 SPI slave).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, data width; byte enables are DATA_WIDTH/8 wide.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 2, maximum granted-but-unanswered transactions.
REQ-005 SHALL use one clock, clk, and reset rst, which is synchronous and active-high.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 req_i  input  NB_REQ  per-requester request.
REQ-009 addr_i / we_i / be_i / wdata_i  input  NB_REQ x (ADDR_WIDTH / 1 / DATA_WIDTH/8 / DATA_WIDTH)  per-requester command.
REQ-010 gnt_o  output  NB_REQ  per-requester grant.
REQ-011 rvalid_o  output  NB_REQ  per-requester response valid.
REQ-012 rdata_o  output  DATA_WIDTH  shared response data, equal to mem_rdata_i.
REQ-013 mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o  output  widths as REQ-009  memory-side command.
REQ-014 mem_gnt_i  input  1  memory grant; mem_rvalid_i  input  1  memory response valid; mem_rdata_i  input  DATA_WIDTH  response data.
REQ-015 err_o  output  1  sticky protocol-error flag.

Function
REQ-016 Handshake: a transaction transfers in a cycle where mem_req_o=1 and mem_gnt_i=1; gnt_o[sel]=mem_gnt_i & mem_req_o, combinational, and all other gnt_o bits are 0.
REQ-017 Selection: round-robin; search starts at (last_granted+1) mod NB_REQ; the first asserted req_i wins.
REQ-018 Lock: once mem_req_o is asserted without mem_gnt_i, the selection is held until a grant occurs or the held requester drops req_i.
REQ-019 last_granted updates only on a completed handshake.
REQ-020 Command muxing: mem_addr_o/we/be/wdata are taken from the selected requester; they are don't-care when mem_req_o=0.
REQ-021 mem_req_o = |req_i & ~fifo_full, where fifo_full means MAX_OUTSTANDING IDs are pending.
REQ-022 On every handshake, the granted requester index is pushed into the in-order ID FIFO.
REQ-023 When mem_rvalid_i=1, the FIFO head is popped and rvalid_o[head]=1 in that same cycle, with no added latency.
REQ-024 Simultaneous push and pop in a full FIFO is not allowed; mem_req_o is already low when full (REQ-021).
REQ-025 Simultaneous push and pop in a non-full FIFO SHALL keep the occupancy unchanged.
REQ-026 If mem_rvalid_i=1 while the FIFO is empty, all rvalid_o stay 0 and err_o is set until reset.
REQ-027 Writes also receive a response: the memory returns rvalid for every granted transaction.
REQ-028 Behaviour with NB_REQ=1: always select 0; round-robin degenerates and latency is unchanged.
REQ-029 The FIFO pointers wrap modulo MAX_OUTSTANDING.

Reset
REQ-030 While rst=1 at a rising clk edge: last_granted=NB_REQ-1 (requester 0 has first priority), lock cleared, FIFO empty, err_o=0.
REQ-031 During and after reset, until a request arrives: mem_req_o=0, gnt_o=0, rvalid_o=0.
REQ-032 Reset mid-transaction discards pending IDs; subsequent responses are not forwarded and set err_o per REQ-026.

Structure
REQ-033 Package tcdm_arb_pkg SHALL hold the NB_REQ and MAX_OUTSTANDING defaults and typedef req_id_t (width $clog2(NB_REQ), minimum 1).
REQ-034 The ID FIFO SHALL be sub-module tcdm_arb_id_fifo (parameters DEPTH and WIDTH; ports push, pop, wdata, rdata, full, empty).
REQ-035 The selection and lock logic SHALL reside in tcdm_rr_arbiter.

Verification
REQ-036 Reset, then req_i=3'b111 with mem_gnt_i tied to 1: grants occur in order 0,1,2,0,... on consecutive cycles, with mem_rvalid_i one cycle after each grant.
REQ-037 req_i[1]=1, addr_i[1]=32'h0010_0040, mem_gnt_i low for 3 cycles: mem_addr_o stays 32'h0010_0040 while req_i[2] is raised meanwhile; gnt_o=3'b010 on the 4th cycle.
REQ-038 Two grants (requester 2, then 0) with mem_gnt_i=1 and no rvalid: mem_req_o=0 on the 3rd cycle; rvalid then pulses rvalid_o[2], then rvalid_o[0], with rdata_o=mem_rdata_i.
REQ-039 mem_rvalid_i=1 with the FIFO empty: rvalid_o=0 and err_o=1, which persists until rst=1, after which err_o=0.
REQ-040 Grant to requester 1, then rst=1 for one cycle, then mem_rvalid_i=1: no rvalid_o, err_o=1, and the next grant goes to requester 0 first.
REQ-041 Same-cycle mem_rvalid_i and a new grant with one ID pending: occupancy stays 1 and the response is routed to the older ID.
